// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      PAR_NONE,
      PAR_EVEN,
      PAR_ODD
   } parity_t;

   localparam int MIN_DBITS = 5;
   localparam int STOP_MAX  = 2;

   // Out-of-range word lengths fall back to the widest supported word.
   function automatic logic [3:0] eff_dbits(input logic [3:0] req, input logic [3:0] max_d);
      if (req < 4'(MIN_DBITS) || req > max_d) return max_d;
      return req;
   endfunction

   function automatic parity_t parity_mode(input logic en, input logic odd);
      if (!en) return PAR_NONE;
      return odd ? PAR_ODD : PAR_EVEN;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush, full/empty flags and occupancy count.
// Latency: a push is visible at rd_data/empty/level one cycle after the write edge.
// Backpressure: pushes while full are ignored; pops while empty are ignored; flush beats push.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   input  logic                     flush,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push;
   logic             pop;

   assign push    = wr_en & ~full & ~flush;
   assign pop     = rd_en & ~empty;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign rd_data = mem[rd_ptr];

   // Pointers and occupancy; flush discards everything including a same-cycle push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array, written only on accepted pushes.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: FIFO-buffered words serialised as start/data/parity/stop frames.
// Latency: line drops one cycle after the IDLE->START pop; each bit lasts baud_div+1 cycles.
// Backpressure: full_o flags a full FIFO; pushes while full are dropped and pulse ovf_o.
module uart_tx_engine #(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16,
   parameter int MAX_DBITS  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en_i,
   input  logic [MAX_DBITS-1:0]          wr_data_i,
   input  logic                          flush_i,
   input  logic                          tx_en_i,
   input  logic [DIV_W-1:0]              baud_div_i,
   input  logic [3:0]                    dbits_i,
   input  logic                          par_en_i,
   input  logic                          par_odd_i,
   input  logic                          stop2_i,
   output logic                          utxd_o,
   output logic                          full_o,
   output logic                          empty_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          ovf_o
);

   import uart_pkg::*;

   localparam logic [3:0] MAXD = 4'(MAX_DBITS);

   logic [MAX_DBITS-1:0] fifo_dat;
   logic                 pop;

   sync_fifo #(
      .WIDTH (MAX_DBITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en_i),
      .wr_data (wr_data_i),
      .rd_en   (pop),
      .rd_data (fifo_dat),
      .flush   (flush_i),
      .full    (full_o),
      .empty   (empty_o),
      .level   (level_o)
   );

   tx_state_t            state, state_n;
   logic [DIV_W-1:0]     cnt, cnt_n;
   logic [DIV_W-1:0]     div_q, div_n;
   logic [3:0]           bit_idx, bit_idx_n;
   logic [3:0]           dbits_q, dbits_n;
   logic [1:0]           stop_idx, stop_idx_n;
   logic [1:0]           nstop_q, nstop_n;
   parity_t              par_q, par_n;
   logic [MAX_DBITS-1:0] sh_q, sh_n;
   logic                 par_bit_q, par_bit_n;
   logic                 frame_end;
   logic                 load;
   logic                 tick;
   logic                 start_ok;
   logic [3:0]           ld_dbits;
   logic [MAX_DBITS-1:0] ld_data;
   logic                 ld_par;

   assign tick     = (cnt == '0);
   assign start_ok = tx_en_i & ~empty_o;

   // Frame snapshot taken at the pop: head word masked to the word length, parity precomputed.
   always_comb begin
      ld_dbits = eff_dbits(dbits_i, MAXD);
      ld_data  = '0;
      for (int i = 0; i < MAX_DBITS; i++) begin
         if (4'(i) < ld_dbits) ld_data[i] = fifo_dat[i];
      end
      ld_par = (^ld_data) ^ par_odd_i;
   end

   // Next-state, bit timing and line output.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      div_n      = div_q;
      bit_idx_n  = bit_idx;
      dbits_n    = dbits_q;
      stop_idx_n = stop_idx;
      nstop_n    = nstop_q;
      par_n      = par_q;
      sh_n       = sh_q;
      par_bit_n  = par_bit_q;
      load       = 1'b0;
      frame_end  = 1'b0;
      pop        = 1'b0;
      utxd_o     = 1'b1;
      busy_o     = (state != IDLE);

      if (state != IDLE && !tick) cnt_n = cnt - DIV_W'(1);

      case (state)
         IDLE: begin
            if (start_ok) load = 1'b1;
         end
         START: begin
            utxd_o = 1'b0;
            if (tick) begin
               state_n   = DATA;
               cnt_n     = div_q;
               bit_idx_n = '0;
            end
         end
         DATA: begin
            utxd_o = sh_q[0];
            if (tick) begin
               cnt_n = div_q;
               sh_n  = sh_q >> 1;
               if (bit_idx == dbits_q - 4'd1) begin
                  state_n    = (par_q == PAR_NONE) ? STOP : PARITY;
                  stop_idx_n = '0;
               end else begin
                  bit_idx_n = bit_idx + 4'd1;
               end
            end
         end
         PARITY: begin
            utxd_o = par_bit_q;
            if (tick) begin
               state_n    = STOP;
               cnt_n      = div_q;
               stop_idx_n = '0;
            end
         end
         STOP: begin
            if (tick) begin
               if (stop_idx != nstop_q - 2'd1) begin
                  stop_idx_n = stop_idx + 2'd1;
                  cnt_n      = div_q;
               end else begin
                  frame_end = 1'b1;
                  if (start_ok) load = 1'b1;
                  else          state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      if (load) begin
         pop       = 1'b1;
         state_n   = START;
         cnt_n     = baud_div_i;
         div_n     = baud_div_i;
         dbits_n   = ld_dbits;
         par_n     = parity_mode(par_en_i, par_odd_i);
         nstop_n   = stop2_i ? 2'(STOP_MAX) : 2'd1;
         sh_n      = ld_data;
         par_bit_n = ld_par;
      end
   end

   // Frame state and latched configuration; reset aborts any frame in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         div_q     <= '0;
         bit_idx   <= '0;
         dbits_q   <= '0;
         stop_idx  <= '0;
         nstop_q   <= '0;
         par_q     <= PAR_NONE;
         sh_q      <= '0;
         par_bit_q <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         div_q     <= div_n;
         bit_idx   <= bit_idx_n;
         dbits_q   <= dbits_n;
         stop_idx  <= stop_idx_n;
         nstop_q   <= nstop_n;
         par_q     <= par_n;
         sh_q      <= sh_n;
         par_bit_q <= par_bit_n;
      end
   end

   // One-cycle event pulses: frame completion and dropped push (flush suppresses overflow).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_o <= 1'b0;
         ovf_o  <= 1'b0;
      end else begin
         done_o <= frame_end;
         ovf_o  <= wr_en_i & full_o & ~flush_i;
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: frame shapes, FIFO limits, flush, tx_en drop, reset abort.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_engine;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic        flush;
   logic        tx_en;
   logic [15:0] baud_div;
   logic [3:0]  dbits;
   logic        par_en;
   logic        par_odd;
   logic        stop2;
   logic        utxd;
   logic        full;
   logic        empty;
   logic [4:0]  level;
   logic        busy;
   logic        done;
   logic        ovf;

   int vectors;
   int miscompares;

   uart_tx_engine #(
      .FIFO_DEPTH (16),
      .DIV_W      (16),
      .MAX_DBITS  (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (wr_en),
      .wr_data_i  (wr_data),
      .flush_i    (flush),
      .tx_en_i    (tx_en),
      .baud_div_i (baud_div),
      .dbits_i    (dbits),
      .par_en_i   (par_en),
      .par_odd_i  (par_odd),
      .stop2_i    (stop2),
      .utxd_o     (utxd),
      .full_o     (full),
      .empty_o    (empty),
      .level_o    (level),
      .busy_o     (busy),
      .done_o     (done),
      .ovf_o      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_cfg(input int div, input int db, input logic pe, input logic po, input logic s2);
      baud_div = 16'(div);
      dbits    = 4'(db);
      par_en   = pe;
      par_odd  = po;
      stop2    = s2;
   endtask

   task automatic push(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   // Waits for the start bit, then records n line samples plus one trailing sample.
   task automatic capture(input int n, input bit scramble, output logic [63:0] line,
                          output int lat, output int dones, output logic idle_line,
                          output logic idle_busy);
      lat   = 0;
      dones = 0;
      line  = '0;
      while (utxd !== 1'b0 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         line[i] = utxd;
         if (done === 1'b1) dones++;
         if (scramble && i == 0) set_cfg(7, 8, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      idle_line = utxd;
      idle_busy = busy;
      if (done === 1'b1) dones++;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      vectors++; if (utxd !== 1'b1)  begin miscompares++; $display("FAIL reset_utxd: got %b want 1", utxd); end
      vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
      vectors++; if (full !== 1'b0)  begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
      vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", level); end
      vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (done !== 1'b0)  begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
      vectors++; if (ovf !== 1'b0)   begin miscompares++; $display("FAIL reset_ovf: got %b want 0", ovf); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_frame_a5;
      logic [63:0] line;
      int          lat, dones;
      logic        il, ib;
      int          exp_cells[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
      logic [3:0]  obs, expv;
      set_cfg(3, 8, 1'b0, 1'b0, 1'b0);
      tx_en = 1'b1;
      push(8'hA5);
      capture(40, 1'b0, line, lat, dones, il, ib);
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL a5_latency: got %0d want 1", lat); end
      for (int c = 0; c < 10; c++) begin
         obs  = line[c*4 +: 4];
         expv = (exp_cells[c] == 1) ? 4'hF : 4'h0;
         vectors++;
         if (obs !== expv) begin
            miscompares++;
            $display("FAIL a5_cell%0d: got %b want %b", c, obs, expv);
         end
      end
      vectors++; if (dones !== 1) begin miscompares++; $display("FAIL a5_done: got %0d pulses want 1", dones); end
      vectors++; if (il !== 1'b1) begin miscompares++; $display("FAIL a5_idle_line: got %b want 1", il); end
      vectors++; if (ib !== 1'b0) begin miscompares++; $display("FAIL a5_idle_busy: got %b want 0", ib); end
   endtask

   task automatic test_frame_55_odd_2stop;
      logic [63:0] line;
      int          lat, dones;
      logic        il, ib;
      set_cfg(0, 7, 1'b1, 1'b1, 1'b1);
      push(8'h55);
      capture(11, 1'b0, line, lat, dones, il, ib);
      vectors++; if (line[10:0] !== 11'b11110101010) begin miscompares++; $display("FAIL f55_line: got %b want %b", line[10:0], 11'b11110101010); end
      vectors++; if (dones !== 1) begin miscompares++; $display("FAIL f55_done: got %0d pulses want 1", dones); end
      vectors++; if (il !== 1'b1) begin miscompares++; $display("FAIL f55_idle_line: got %b want 1", il); end
   endtask

   task automatic test_cfg_change_midframe;
      logic [63:0] line;
      int          lat, dones;
      logic        il, ib;
      set_cfg(1, 5, 1'b1, 1'b0, 1'b0);
      push(8'hF3);
      capture(16, 1'b1, line, lat, dones, il, ib);
      vectors++; if (line[15:0] !== 16'b1111110000111100) begin miscompares++; $display("FAIL cfgchg_line: got %b want %b", line[15:0], 16'b1111110000111100); end
      vectors++; if (dones !== 1) begin miscompares++; $display("FAIL cfgchg_done: got %0d pulses want 1", dones); end
      vectors++; if (il !== 1'b1) begin miscompares++; $display("FAIL cfgchg_idle_line: got %b want 1", il); end
   endtask

   task automatic test_dbits_clamp;
      logic [63:0] line;
      int          lat, dones;
      logic        il, ib;
      set_cfg(0, 3, 1'b0, 1'b0, 1'b0);
      push(8'hC3);
      capture(10, 1'b0, line, lat, dones, il, ib);
      vectors++; if (line[9:0] !== 10'b1110000110) begin miscompares++; $display("FAIL clamp_line: got %b want %b", line[9:0], 10'b1110000110); end
      vectors++; if (il !== 1'b1) begin miscompares++; $display("FAIL clamp_idle_line: got %b want 1", il); end
   endtask

   task automatic test_full_back_to_back;
      int           ovfs, lat, dones;
      logic [199:0] cap;
      logic [9:0]   obs, expv;
      tx_en = 1'b0;
      set_cfg(0, 8, 1'b0, 1'b0, 1'b0);
      ovfs = 0;
      for (int i = 0; i < 17; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'(8'h30 + i);
         @(negedge clk);
         if (ovf === 1'b1) ovfs++;
      end
      wr_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (ovf === 1'b1) ovfs++;
      end
      vectors++; if (level !== 5'd16) begin miscompares++; $display("FAIL full_level: got %0d want 16", level); end
      vectors++; if (full !== 1'b1)   begin miscompares++; $display("FAIL full_flag: got %b want 1", full); end
      vectors++; if (ovfs !== 1)      begin miscompares++; $display("FAIL full_ovf: got %0d pulses want 1", ovfs); end
      vectors++; if (busy !== 1'b0)   begin miscompares++; $display("FAIL full_busy_txdis: got %b want 0", busy); end
      tx_en = 1'b1;
      lat   = 0;
      while (utxd !== 1'b0 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL b2b_start: got %0d cycles want 1", lat); end
      cap   = '0;
      dones = 0;
      for (int i = 0; i < 161; i++) begin
         if (i > 0) @(negedge clk);
         cap[i] = utxd;
         if (done === 1'b1) dones++;
      end
      for (int k = 0; k < 16; k++) begin
         obs  = cap[k*10 +: 10];
         expv = {1'b1, 8'(8'h30 + k), 1'b0};
         vectors++;
         if (obs !== expv) begin
            miscompares++;
            $display("FAIL b2b_frame%0d: got %b want %b", k, obs, expv);
         end
      end
      vectors++; if (dones !== 16)  begin miscompares++; $display("FAIL b2b_done: got %0d pulses want 16", dones); end
      vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL b2b_empty: got %b want 1", empty); end
      vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL b2b_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_midframe;
      int dones, lows;
      set_cfg(3, 8, 1'b0, 1'b0, 1'b0);
      tx_en = 1'b1;
      push(8'hA5);
      push(8'h11);
      push(8'h22);
      vectors++; if (level !== 5'd2) begin miscompares++; $display("FAIL rstmf_level_pre: got %0d want 2", level); end
      repeat (9) @(negedge clk);
      vectors++; if (utxd !== 1'b0) begin miscompares++; $display("FAIL rstmf_line_pre: got %b want 0", utxd); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rstmf_busy_pre: got %b want 1", busy); end
      rst = 1'b1;
      #1;
      vectors++; if (utxd !== 1'b1)  begin miscompares++; $display("FAIL rstmf_line: got %b want 1", utxd); end
      vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL rstmf_level: got %0d want 0", level); end
      vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rstmf_empty: got %b want 1", empty); end
      vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL rstmf_busy: got %b want 0", busy); end
      @(negedge clk);
      rst   = 1'b0;
      dones = 0;
      lows  = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
         if (utxd !== 1'b1) lows++;
      end
      vectors++; if (dones !== 0) begin miscompares++; $display("FAIL rstmf_done: got %0d pulses want 0", dones); end
      vectors++; if (lows !== 0)  begin miscompares++; $display("FAIL rstmf_line_after: got %0d low cycles want 0", lows); end
   endtask

   task automatic test_txen_drop;
      int   waited, lows;
      bit   seen;
      set_cfg(1, 8, 1'b0, 1'b0, 1'b0);
      tx_en = 1'b1;
      push(8'h01);
      push(8'h02);
      push(8'h03);
      push(8'h04);
      vectors++; if (level !== 5'd3) begin miscompares++; $display("FAIL txdrop_level_pre: got %0d want 3", level); end
      tx_en  = 1'b0;
      seen   = 1'b0;
      waited = 0;
      while (!seen && waited < 100) begin
         @(negedge clk);
         waited++;
         if (done === 1'b1) seen = 1'b1;
      end
      vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL txdrop_done: got no pulse in %0d cycles want 1 pulse", waited); end
      lows = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (utxd !== 1'b1) lows++;
      end
      vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL txdrop_busy: got %b want 0", busy); end
      vectors++; if (level !== 5'd3) begin miscompares++; $display("FAIL txdrop_level: got %0d want 3", level); end
      vectors++; if (lows !== 0)     begin miscompares++; $display("FAIL txdrop_line: got %0d low cycles want 0", lows); end
   endtask

   task automatic test_flush;
      int   idx, ovfs, lows;
      bit   seen;
      tx_en = 1'b1;
      @(negedge clk);
      vectors++; if (level !== 5'd2) begin miscompares++; $display("FAIL flush_level_pre: got %0d want 2", level); end
      flush   = 1'b1;
      wr_en   = 1'b1;
      wr_data = 8'h77;
      @(negedge clk);
      flush = 1'b0;
      wr_en = 1'b0;
      ovfs  = (ovf === 1'b1) ? 1 : 0;
      vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL flush_level: got %0d want 0", level); end
      vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL flush_empty: got %b want 1", empty); end
      vectors++; if (busy !== 1'b1)  begin miscompares++; $display("FAIL flush_busy: got %b want 1", busy); end
      idx  = 1;
      seen = 1'b0;
      while (!seen && idx < 100) begin
         @(negedge clk);
         idx++;
         if (ovf === 1'b1) ovfs++;
         if (done === 1'b1) seen = 1'b1;
      end
      vectors++; if (idx !== 20) begin miscompares++; $display("FAIL flush_frame_len: got done at %0d want 20", idx); end
      lows = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (utxd !== 1'b1) lows++;
      end
      vectors++; if (ovfs !== 0)    begin miscompares++; $display("FAIL flush_ovf: got %0d pulses want 0", ovfs); end
      vectors++; if (lows !== 0)    begin miscompares++; $display("FAIL flush_no_new_frame: got %0d low cycles want 0", lows); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_busy_end: got %b want 0", busy); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst      = 1'b1;
      wr_en    = 1'b0;
      wr_data  = 8'h00;
      flush    = 1'b0;
      tx_en    = 1'b0;
      baud_div = 16'd0;
      dbits    = 4'd8;
      par_en   = 1'b0;
      par_odd  = 1'b0;
      stop2    = 1'b0;
      test_reset();
      test_frame_a5();
      test_frame_55_odd_2stop();
      test_cfg_change_midframe();
      test_dbits_clamp();
      test_full_back_to_back();
      test_reset_midframe();
      test_txen_drop();
      test_flush();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
